// File: rtl/eth_tx_frame_arbiter_if.sv
// Handshake bundle between the frame sources, the TX arbiter and the MAC TX stream.
// Source i occupies s_axis_tdata[8i+7:8i]; all other s_* vectors are one bit per source.
interface eth_tx_frame_arbiter_if #(
  parameter int unsigned N_SRC = 3
) ();
  logic [8*N_SRC-1:0] s_axis_tdata;
  logic [N_SRC-1:0]   s_axis_tvalid;
  logic [N_SRC-1:0]   s_axis_tready;
  logic [N_SRC-1:0]   s_axis_tlast;
  logic [N_SRC-1:0]   s_axis_tuser;
  logic [7:0]         m_axis_tdata;
  logic               m_axis_tvalid;
  logic               m_axis_tready;
  logic               m_axis_tlast;
  logic               m_axis_tuser;

  // Arbiter view: sinks the source streams, sources the MAC stream.
  modport slave (
    input  s_axis_tdata, s_axis_tvalid, s_axis_tlast, s_axis_tuser, m_axis_tready,
    output s_axis_tready, m_axis_tdata, m_axis_tvalid, m_axis_tlast, m_axis_tuser
  );

  // Environment view: frame generators plus the MAC.
  modport master (
    output s_axis_tdata, s_axis_tvalid, s_axis_tlast, s_axis_tuser, m_axis_tready,
    input  s_axis_tready, m_axis_tdata, m_axis_tvalid, m_axis_tlast, m_axis_tuser
  );
endinterface

// File: rtl/eth_tx_frame_arbiter.sv
// Frame-granular round-robin arbiter onto the single 8-bit MAC TX stream.
// Over-length or stalled frames are cut with tuser=1 and the remainder is drained.
module eth_tx_frame_arbiter #(
  parameter int unsigned N_SRC         = 3,
  parameter int unsigned MAX_FRAME_LEN = 1518,
  parameter int unsigned STALL_TIMEOUT = 255
) (
  input  logic                  clk,
  input  logic                  rst,
  eth_tx_frame_arbiter_if.slave bus,
  output logic [N_SRC-1:0]      grant,
  output logic                  busy,
  output logic                  abort_pulse
);
  localparam int unsigned IDX_W   = $clog2(N_SRC);
  localparam int unsigned BEAT_W  = $clog2(MAX_FRAME_LEN + 1);
  localparam int unsigned STALL_W = $clog2(STALL_TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, PASS, TERM, DROP} state_t;

  state_t             state;
  logic [IDX_W-1:0]   rr_ptr;
  logic [IDX_W-1:0]   gidx;
  logic [IDX_W-1:0]   pick;
  logic [IDX_W-1:0]   cand;
  logic [IDX_W-1:0]   next_ptr;
  logic               found;
  logic [BEAT_W-1:0]  beat_cnt;
  logic [STALL_W-1:0] stall_cnt;
  logic [7:0]         sel_data;
  logic               sel_valid;
  logic               sel_last;
  logic               sel_user;
  logic               at_limit;
  logic               m_hs;

  // First requesting source at or after rr_ptr, with wrap-around.
  always_comb begin
    pick  = '0;
    cand  = '0;
    found = 1'b0;
    for (int unsigned k = 0; k < N_SRC; k++) begin
      cand = IDX_W'((32'(rr_ptr) + k) % N_SRC);
      if (!found && bus.s_axis_tvalid[cand]) begin
        found = 1'b1;
        pick  = cand;
      end
    end
  end

  // Granted source's stream.
  always_comb begin
    sel_data  = '0;
    sel_valid = 1'b0;
    sel_last  = 1'b0;
    sel_user  = 1'b0;
    for (int unsigned i = 0; i < N_SRC; i++) begin
      if (gidx == IDX_W'(i)) begin
        sel_data  = bus.s_axis_tdata[8*i +: 8];
        sel_valid = bus.s_axis_tvalid[i];
        sel_last  = bus.s_axis_tlast[i];
        sel_user  = bus.s_axis_tuser[i];
      end
    end
  end

  assign next_ptr = (gidx == IDX_W'(N_SRC - 1)) ? '0 : gidx + IDX_W'(1);
  // A native tlast on the final allowed beat keeps the frame legal.
  assign at_limit = (beat_cnt == BEAT_W'(MAX_FRAME_LEN - 1)) && !sel_last;
  assign m_hs     = (state == PASS) && sel_valid && bus.m_axis_tready;

  // Zero-latency passthrough in PASS; synthetic bad-frame terminator in TERM.
  always_comb begin
    bus.m_axis_tdata  = '0;
    bus.m_axis_tvalid = 1'b0;
    bus.m_axis_tlast  = 1'b0;
    bus.m_axis_tuser  = 1'b0;
    bus.s_axis_tready = '0;
    case (state)
      PASS: begin
        bus.m_axis_tdata  = sel_data;
        bus.m_axis_tvalid = sel_valid;
        bus.m_axis_tlast  = sel_last | at_limit;
        bus.m_axis_tuser  = sel_user | at_limit;
        bus.s_axis_tready = grant & {N_SRC{bus.m_axis_tready}};
      end
      TERM: begin
        bus.m_axis_tvalid = 1'b1;
        bus.m_axis_tlast  = 1'b1;
        bus.m_axis_tuser  = 1'b1;
      end
      DROP:    bus.s_axis_tready = grant;
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      rr_ptr      <= '0;
      gidx        <= '0;
      grant       <= '0;
      busy        <= 1'b0;
      abort_pulse <= 1'b0;
      beat_cnt    <= '0;
      stall_cnt   <= '0;
    end else begin
      abort_pulse <= 1'b0;
      unique case (state)
        IDLE: begin
          if (|bus.s_axis_tvalid) begin
            state     <= PASS;
            busy      <= 1'b1;
            gidx      <= pick;
            grant     <= N_SRC'(1) << pick;
            beat_cnt  <= '0;
            stall_cnt <= '0;
          end
        end
        PASS: begin
          if (m_hs) begin
            beat_cnt  <= beat_cnt + BEAT_W'(1);
            stall_cnt <= '0;
            if (sel_last) begin
              state  <= IDLE;
              busy   <= 1'b0;
              grant  <= '0;
              rr_ptr <= next_ptr;
            end else if (at_limit) begin
              abort_pulse <= 1'b1;
              state       <= DROP;
            end
          end else if (!sel_valid) begin
            // MAC backpressure with valid data held is not counted as a stall.
            if (stall_cnt == STALL_W'(STALL_TIMEOUT - 1)) begin
              if (beat_cnt == '0) begin
                state  <= IDLE;
                busy   <= 1'b0;
                grant  <= '0;
                rr_ptr <= next_ptr;
              end else begin
                state <= TERM;
              end
            end else begin
              stall_cnt <= stall_cnt + STALL_W'(1);
            end
          end
        end
        TERM: begin
          if (bus.m_axis_tready) begin
            abort_pulse <= 1'b1;
            state       <= DROP;
          end
        end
        DROP: begin
          if (sel_valid && sel_last) begin
            state  <= IDLE;
            busy   <= 1'b0;
            grant  <= '0;
            rr_ptr <= next_ptr;
          end
        end
      endcase
    end
  end
endmodule

// File: tb/tb_eth_tx_frame_arbiter.sv
// Directed bench for eth_tx_frame_arbiter: queued source frames, scoreboard of
// expected MAC beats (data/last/user/owner/spacing) popped on each m handshake.
module tb_eth_tx_frame_arbiter;
  localparam int unsigned N_SRC   = 3;
  localparam int unsigned MAX_LEN = 1518;

  typedef struct { logic [7:0] data; logic last; logic user; int gap; } sbeat_t;
  typedef struct { int src; logic [7:0] data; logic last; logic user; int dt; } mbeat_t;

  logic             clk = 1'b0;
  logic             rst;
  logic [N_SRC-1:0] grant;
  logic             busy;
  logic             abort_pulse;
  int               checks = 0;
  int               errors = 0;
  int               beats  = 0;
  int               aborts = 0;
  sbeat_t           src_q [N_SRC][$];
  mbeat_t           exp_q [$];

  eth_tx_frame_arbiter_if #(.N_SRC(N_SRC)) bus ();

  eth_tx_frame_arbiter #(
    .N_SRC(N_SRC), .MAX_FRAME_LEN(MAX_LEN), .STALL_TIMEOUT(255)
  ) dut (
    .clk(clk), .rst(rst), .bus(bus),
    .grant(grant), .busy(busy), .abort_pulse(abort_pulse)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Queue a source frame; beat stall_at is preceded by stall_len cycles of tvalid=0.
  task automatic add_frame(input int src, input int len, input int base, input int stall_at, input int stall_len);
    sbeat_t b;
    for (int i = 0; i < len; i++) begin
      b.data = 8'(base + i);
      b.last = (i == len - 1);
      b.user = 1'b0;
      b.gap  = (i == stall_at) ? stall_len : 0;
      src_q[src].push_back(b);
    end
  endtask

  // dt: required negedge count since the previous m handshake (0 = unchecked).
  task automatic exp_beat(input int src, input logic [7:0] data, input logic last, input logic user, input int dt);
    mbeat_t e;
    e.src = src; e.data = data; e.last = last; e.user = user; e.dt = dt;
    exp_q.push_back(e);
  endtask

  task automatic exp_frame(input int src, input int len, input int base, input int dt_first, input int dt_rest);
    for (int i = 0; i < len; i++)
      exp_beat(src, 8'(base + i), i == len - 1, 1'b0, (i == 0) ? dt_first : dt_rest);
  endtask

  function automatic bit all_idle();
    bit idle;
    idle = (exp_q.size() == 0) && (busy == 1'b0) && (bus.s_axis_tvalid == '0);
    for (int i = 0; i < N_SRC; i++) if (src_q[i].size() != 0) idle = 1'b0;
    return idle;
  endfunction

  task automatic wait_done(input string tag, input int budget);
    bit done;
    done = 1'b0;
    for (int c = 0; c < budget && !done; c++) begin
      @(negedge clk);
      done = all_idle();
    end
    chk({tag, "_complete"}, 64'(done), 64'd1);
  endtask

  // Source models: present queued beats, pop on handshake, drop everything in reset.
  initial begin : src_driver
    logic [N_SRC-1:0] hs;
    sbeat_t           b;
    bus.s_axis_tdata  = '0;
    bus.s_axis_tvalid = '0;
    bus.s_axis_tlast  = '0;
    bus.s_axis_tuser  = '0;
    forever begin
      @(negedge clk);
      hs = bus.s_axis_tvalid & bus.s_axis_tready;
      @(posedge clk);
      #1;
      for (int i = 0; i < N_SRC; i++) begin
        if (rst) begin
          bus.s_axis_tvalid[i] = 1'b0;
        end else begin
          if (hs[i]) begin
            if (src_q[i].size() != 0) void'(src_q[i].pop_front());
            bus.s_axis_tvalid[i] = 1'b0;
          end
          if (!bus.s_axis_tvalid[i] && src_q[i].size() != 0) begin
            b = src_q[i][0];
            if (b.gap > 0) begin
              b.gap = b.gap - 1;
              src_q[i][0] = b;
            end else begin
              bus.s_axis_tvalid[i]        = 1'b1;
              bus.s_axis_tdata[8*i +: 8]  = b.data;
              bus.s_axis_tlast[i]         = b.last;
              bus.s_axis_tuser[i]         = b.user;
            end
          end
        end
      end
    end
  end

  // MAC-side scoreboard.
  initial begin : m_monitor
    longint cyc;
    longint last_hs;
    mbeat_t e;
    cyc = 0;
    last_hs = 0;
    forever begin
      @(negedge clk);
      cyc++;
      if (abort_pulse === 1'b1) aborts++;
      if (rst === 1'b0 && bus.m_axis_tvalid === 1'b1 && bus.m_axis_tready === 1'b1) begin
        chk("beat_expected", 64'(exp_q.size() != 0), 64'd1);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          chk("m_tdata", 64'(bus.m_axis_tdata), 64'(e.data));
          chk("m_tlast", 64'(bus.m_axis_tlast), 64'(e.last));
          chk("m_tuser", 64'(bus.m_axis_tuser), 64'(e.user));
          chk("beat_owner", 64'(grant), 64'(1) << e.src);
          chk("tready_others", 64'(bus.s_axis_tready & ~grant), 64'd0);
          if (e.dt > 0) chk("beat_spacing", 64'(cyc - last_hs), 64'(e.dt));
        end
        last_hs = cyc;
        beats++;
      end
    end
  end

  initial begin : stim
    int a0;
    int b0;
    rst = 1'b1;
    bus.m_axis_tready = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_grant", 64'(grant), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_abort", 64'(abort_pulse), 64'd0);
    chk("rst_m_bus", 64'({bus.m_axis_tvalid, bus.m_axis_tlast, bus.m_axis_tuser, bus.m_axis_tdata}), 64'd0);
    chk("rst_s_tready", 64'(bus.s_axis_tready), 64'd0);
    rst = 1'b0;
    @(negedge clk);

    // Single source, 64 beats: one arbitration cycle, then contiguous passthrough.
    add_frame(1, 64, 0, -1, 0);
    exp_frame(1, 64, 0, 0, 1);
    @(negedge clk);
    chk("t1_arb_grant", 64'(grant), 64'd0);
    chk("t1_arb_tvalid", 64'(bus.m_axis_tvalid), 64'd0);
    @(negedge clk);
    chk("t1_pass_grant", 64'(grant), 64'b010);
    chk("t1_pass_busy", 64'(busy), 64'd1);
    chk("t1_pass_tready", 64'(bus.s_axis_tready), 64'b010);
    chk("t1_first_tvalid", 64'(bus.m_axis_tvalid), 64'd1);
    wait_done("t1", 200);
    chk("t1_grant_after", 64'(grant), 64'd0);

    // All sources back-to-back; rr_ptr=2 after src1, so order is 2,0,1,2,0,1.
    for (int f = 0; f < 2; f++)
      for (int s = 0; s < 3; s++) add_frame(s, 10, 64*s + 16*f, -1, 0);
    for (int k = 0; k < 6; k++)
      exp_frame((2 + k) % 3, 10, 64*((2 + k) % 3) + 16*(k / 3), (k == 0) ? 0 : 2, 1);
    wait_done("t2", 300);

    // Backpressure every other cycle is not a stall.
    a0 = aborts;
    add_frame(0, 20, 160, -1, 0);
    exp_frame(0, 20, 160, 0, 0);
    for (int c = 0; c < 300 && !all_idle(); c++) begin
      @(posedge clk);
      #1;
      bus.m_axis_tready = ~bus.m_axis_tready;
    end
    chk("t3_complete", 64'(all_idle()), 64'd1);
    chk("t3_no_abort", 64'(aborts - a0), 64'd0);
    bus.m_axis_tready = 1'b1;
    @(negedge clk);

    // Stall of src2 after 5 beats: terminator beat, then drain to its tlast.
    a0 = aborts;
    add_frame(2, 12, 200, 5, 300);
    for (int i = 0; i < 5; i++) exp_beat(2, 8'(200 + i), 1'b0, 1'b0, (i == 0) ? 0 : 1);
    exp_beat(2, 8'h00, 1'b1, 1'b1, 0);
    for (int c = 0; c < 400 && abort_pulse !== 1'b1; c++) @(negedge clk);
    chk("t4_abort_seen", 64'(abort_pulse), 64'd1);
    add_frame(0, 8, 16, -1, 0);
    add_frame(1, 8, 32, -1, 0);
    exp_frame(0, 8, 16, 0, 1);
    exp_frame(1, 8, 32, 2, 1);
    @(negedge clk);
    chk("t4_abort_one_cycle", 64'(abort_pulse), 64'd0);
    chk("t4_drop_grant", 64'(grant), 64'b100);
    chk("t4_drop_tvalid", 64'(bus.m_axis_tvalid), 64'd0);
    chk("t4_drop_tready", 64'(bus.s_axis_tready), 64'b100);
    wait_done("t4", 300);
    chk("t4_abort_count", 64'(aborts - a0), 64'd1);

    // 1600-beat frame is cut at beat 1518; a native 1518-beat frame is clean.
    a0 = aborts;
    add_frame(0, 1600, 0, -1, 0);
    add_frame(0, MAX_LEN, 7, -1, 0);
    for (int i = 0; i < MAX_LEN; i++)
      exp_beat(0, 8'(i), i == MAX_LEN - 1, i == MAX_LEN - 1, (i == 0) ? 0 : 1);
    exp_frame(0, MAX_LEN, 7, 0, 1);
    wait_done("t5", 4000);
    chk("t5_abort_count", 64'(aborts - a0), 64'd1);

    // Move rr_ptr to 2, then reset mid-frame at beat 30 of a src2 frame.
    add_frame(1, 4, 80, -1, 0);
    exp_frame(1, 4, 80, 0, 1);
    wait_done("t6_pre", 100);
    b0 = beats;
    add_frame(2, 60, 100, -1, 0);
    for (int i = 0; i < 30; i++) exp_beat(2, 8'(100 + i), 1'b0, 1'b0, (i == 0) ? 0 : 1);
    for (int c = 0; c < 200 && beats < b0 + 30; c++) begin
      @(negedge clk);
      #1;
    end
    chk("t6_beats_before_rst", 64'(beats - b0), 64'd30);
    @(posedge clk);
    #2;
    rst = 1'b1;
    src_q[2].delete();
    #1;
    chk("t6_rst_m_bus", 64'({bus.m_axis_tvalid, bus.m_axis_tlast, bus.m_axis_tuser, bus.m_axis_tdata}), 64'd0);
    chk("t6_rst_s_tready", 64'(bus.s_axis_tready), 64'd0);
    chk("t6_rst_status", 64'({grant, busy, abort_pulse}), 64'd0);
    chk("t6_sb_drained", 64'(exp_q.size()), 64'd0);
    @(posedge clk);
    #2;
    rst = 1'b0;
    add_frame(2, 6, 120, -1, 0);
    add_frame(1, 6, 140, -1, 0);
    exp_frame(1, 6, 140, 0, 1);
    exp_frame(2, 6, 120, 2, 1);
    wait_done("t6", 200);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
